// File: rtl/timer_status_irq_if.sv
// Host-side bus between the register decoder and timer_status_irq:
// write/read strobes, address and data in, status byte and IRQ line out.
interface timer_status_irq_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  wr;
    logic [ADDR_WIDTH-1:0] address;
    logic [7:0]            din;
    logic                  rd;
    logic [7:0]            status;
    logic                  irq_n;

    modport master (
        output wr,
        output address,
        output din,
        output rd,
        input  status,
        input  irq_n
    );

    modport slave (
        input  wr,
        input  address,
        input  din,
        input  rd,
        output status,
        output irq_n
    );
endinterface

// File: rtl/timer_status_irq.sv
// OPL3 timer register endpoint: decodes bank-0 writes to 0x02/0x03/0x04 into
// timer preloads, start and mask bits, latches the timer overflow flags,
// and drives the registered IRQ line and status byte back to the host.
module timer_status_irq #(
    parameter int REG_TIMER_WIDTH = 8,
    parameter int ADDR_WIDTH      = 9
) (
    input  logic                       clk,
    input  logic                       reset_n,
    timer_status_irq_if.slave          host,
    output logic [REG_TIMER_WIDTH-1:0] timer1_reg,
    output logic [REG_TIMER_WIDTH-1:0] timer2_reg,
    output logic                       start_timer1,
    output logic                       start_timer2,
    input  logic                       timer1_overflow_pulse,
    input  logic                       timer2_overflow_pulse
);

    typedef enum logic [7:0] {
        REG_TIMER1  = 8'h02,
        REG_TIMER2  = 8'h03,
        REG_CONTROL = 8'h04
    } reg_addr_e;

    logic [REG_TIMER_WIDTH-1:0] r_timer1;
    logic [REG_TIMER_WIDTH-1:0] r_timer2;
    logic                       r_start1;
    logic                       r_start2;
    logic                       r_mask1;
    logic                       r_mask2;
    logic                       r_ft1;
    logic                       r_ft2;
    logic [7:0]                 r_status;
    logic                       r_irq_n;

    logic                       w_bank0_wr;
    logic                       w_wr_timer1;
    logic                       w_wr_timer2;
    logic                       w_wr_control;
    logic                       w_irq_reset;
    logic                       w_set1;
    logic                       w_set2;
    logic                       w_irq;
    logic                       w_unused;

    // Write decode: bank 1 (address[8]=1) is never acted upon here.
    always_comb begin
        w_bank0_wr   = host.wr && !host.address[8];
        w_wr_timer1  = w_bank0_wr && (host.address[7:0] == REG_TIMER1);
        w_wr_timer2  = w_bank0_wr && (host.address[7:0] == REG_TIMER2);
        w_wr_control = w_bank0_wr && (host.address[7:0] == REG_CONTROL);
        w_irq_reset  = w_wr_control && host.din[7];
        w_set1       = timer1_overflow_pulse && !r_mask1;
        w_set2       = timer2_overflow_pulse && !r_mask2;
        w_irq        = r_ft1 || r_ft2;
    end

    // Reads have no side effects; rd only tells the host when to sample.
    assign w_unused = host.rd;

    // Preload registers for the two timers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer1 <= '0;
            r_timer2 <= '0;
        end else begin
            if (w_wr_timer1) r_timer1 <= REG_TIMER_WIDTH'(host.din);
            if (w_wr_timer2) r_timer2 <= REG_TIMER_WIDTH'(host.din);
        end
    end

    // Control register: an IRQ-reset write leaves start and mask untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask1  <= 1'b0;
            r_mask2  <= 1'b0;
            r_start1 <= 1'b0;
            r_start2 <= 1'b0;
        end else if (w_wr_control && !host.din[7]) begin
            r_mask1  <= host.din[6];
            r_mask2  <= host.din[5];
            r_start2 <= host.din[1];
            r_start1 <= host.din[0];
        end
    end

    // Overflow flags: an unmasked overflow beats a same-cycle IRQ reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ft1 <= 1'b0;
            r_ft2 <= 1'b0;
        end else begin
            r_ft1 <= w_set1 || (r_ft1 && !w_irq_reset);
            r_ft2 <= w_set2 || (r_ft2 && !w_irq_reset);
        end
    end

    // Registered IRQ line and status byte, refreshed every cycle from the flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_n  <= 1'b1;
            r_status <= '0;
        end else begin
            r_irq_n  <= !w_irq;
            r_status <= {w_irq, r_ft1, r_ft2, 5'b0};
        end
    end

    assign timer1_reg   = r_timer1;
    assign timer2_reg   = r_timer2;
    assign start_timer1 = r_start1;
    assign start_timer2 = r_start2;
    assign host.status  = r_status;
    assign host.irq_n   = r_irq_n;

endmodule

// File: tb/tb_timer_status_irq.sv
// Directed bench for timer_status_irq: register decode, flag set/clear
// priority, masking, bank-1 rejection, read stability and async reset.
module tb_timer_status_irq;

    logic       clk;
    logic       reset_n;
    logic [7:0] timer1_reg;
    logic [7:0] timer2_reg;
    logic       start_timer1;
    logic       start_timer2;
    logic       t1_ovf;
    logic       t2_ovf;

    int n_cmp;
    int n_err;

    timer_status_irq_if #(.ADDR_WIDTH(9)) bus ();

    timer_status_irq #(
        .REG_TIMER_WIDTH(8),
        .ADDR_WIDTH     (9)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .host                 (bus.slave),
        .timer1_reg           (timer1_reg),
        .timer2_reg           (timer2_reg),
        .start_timer1         (start_timer1),
        .start_timer2         (start_timer2),
        .timer1_overflow_pulse(t1_ovf),
        .timer2_overflow_pulse(t2_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // One-cycle host write; returns on the negedge after the capturing posedge.
    task automatic host_write(input logic [8:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus.wr      = 1'b1;
        bus.address = addr;
        bus.din     = data;
        @(negedge clk);
        bus.wr      = 1'b0;
    endtask

    task automatic pulse(input logic p1, input logic p2);
        @(negedge clk);
        t1_ovf = p1;
        t2_ovf = p2;
        @(negedge clk);
        t1_ovf = 1'b0;
        t2_ovf = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        reset_n     = 1'b0;
        bus.wr      = 1'b0;
        bus.rd      = 1'b0;
        bus.address = '0;
        bus.din     = '0;
        t1_ovf      = 1'b0;
        t2_ovf      = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(1);

        // Reset state
        check("rst_status", bus.status, 8'h00);
        check("rst_irq_n", {7'b0, bus.irq_n}, 8'h01);
        check("rst_t1reg", timer1_reg, 8'h00);
        check("rst_start", {6'b0, start_timer2, start_timer1}, 8'h00);

        // 1: preload, start, overflow -> flag then IRQ one cycle later
        host_write(9'h002, 8'hF0);
        check("t1reg_F0", timer1_reg, 8'hF0);
        check("t1reg_nostart", {7'b0, start_timer1}, 8'h00);
        host_write(9'h003, 8'h5A);
        check("t2reg_5A", timer2_reg, 8'h5A);
        host_write(9'h004, 8'h01);
        check("start1_set", {6'b0, start_timer2, start_timer1}, 8'h01);
        pulse(1'b1, 1'b0);
        check("irq_n_plus1", {7'b0, bus.irq_n}, 8'h01);
        idle(1);
        check("irq_n_plus2", {7'b0, bus.irq_n}, 8'h00);
        check("status_C0", bus.status, 8'hC0);

        // 4: bank-1 write is ignored
        host_write(9'h104, 8'h80);
        idle(1);
        check("bank1_status", bus.status, 8'hC0);
        check("bank1_irq_n", {7'b0, bus.irq_n}, 8'h00);
        host_write(9'h102, 8'h11);
        check("bank1_t1reg", timer1_reg, 8'hF0);

        // IRQ reset clears FT1 but keeps start bit
        host_write(9'h004, 8'h80);
        idle(1);
        check("irqrst_status", bus.status, 8'h00);
        check("irqrst_irq_n", {7'b0, bus.irq_n}, 8'h01);
        check("irqrst_start", {6'b0, start_timer2, start_timer1}, 8'h01);

        // 2: masked overflow is dropped, unmasking later does not revive it
        host_write(9'h004, 8'h41);
        pulse(1'b1, 1'b0);
        idle(1);
        check("mask_status", bus.status, 8'h00);
        check("mask_irq_n", {7'b0, bus.irq_n}, 8'h01);
        host_write(9'h004, 8'h01);
        idle(1);
        check("unmask_status", bus.status, 8'h00);

        // 3: overflow in same cycle as IRQ reset -> flag survives
        host_write(9'h004, 8'h00);
        pulse(1'b0, 1'b1);
        idle(1);
        check("ft2_status", bus.status, 8'hA0);
        @(negedge clk);
        bus.wr      = 1'b1;
        bus.address = 9'h004;
        bus.din     = 8'h80;
        t2_ovf      = 1'b1;
        @(negedge clk);
        bus.wr = 1'b0;
        t2_ovf = 1'b0;
        idle(1);
        check("race_status", bus.status, 8'hA0);
        check("race_irq_n", {7'b0, bus.irq_n}, 8'h00);
        host_write(9'h004, 8'h80);
        idle(1);
        check("clr2_status", bus.status, 8'h00);
        check("clr2_irq_n", {7'b0, bus.irq_n}, 8'h01);

        // 5: both overflow together, stopping timers keeps flags, reads are benign
        host_write(9'h004, 8'h03);
        check("start_both", {6'b0, start_timer2, start_timer1}, 8'h03);
        pulse(1'b1, 1'b1);
        idle(1);
        check("both_status", bus.status, 8'hE0);
        host_write(9'h004, 8'h00);
        check("stop_both", {6'b0, start_timer2, start_timer1}, 8'h00);
        idle(1);
        check("stop_status", bus.status, 8'hE0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.rd = 1'b1;
            @(negedge clk);
            bus.rd = 1'b0;
            check("read_E0", bus.status, 8'hE0);
        end

        // 6: async reset mid-run with flags and start bits set
        host_write(9'h004, 8'h03);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_status", bus.status, 8'h00);
        check("arst_irq_n", {7'b0, bus.irq_n}, 8'h01);
        check("arst_t1reg", timer1_reg, 8'h00);
        check("arst_t2reg", timer2_reg, 8'h00);
        check("arst_start", {6'b0, start_timer2, start_timer1}, 8'h00);
        idle(1);
        reset_n = 1'b1;
        idle(2);
        check("post_rst_status", bus.status, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
